// File: rtl/repeated_sub_divider_pkg.sv
// Shared definitions for the repeated-subtraction divider.
//   divider_state_t : FSM encoding (IDLE, RUN, DONE on 2 bits)
//   DEFAULT_WIDTH   : default operand / result width
package divider_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } divider_state_t;

endpackage

// File: rtl/repeated_sub_divider_if.sv
// Handshake and result bundle of the repeated-subtraction divider.
//   start/dividend/divisor : request side, driven by the master
//   busy/done              : status, driven by the divider
//   quotient/remainder     : results, held until the next accepted start
//   div_by_zero            : flag raised with done when the divisor was 0
interface repeated_sub_divider_if import divider_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/repeated_sub_divider.sv
// Sequential unsigned divider: subtracts the divisor once per cycle until
// the remainder drops below it, counting subtractions into the quotient.
//   CLK : system clock, rising edge
//   RST : asynchronous active-high reset (aborts any running division)
//   bus : repeated_sub_divider_if slave (start/operands in, status/results out)
// Latency from the accepting edge to done: Q+1 edges, or 0 edges when the
// divisor is zero (done then appears in the very next cycle).
module repeated_sub_divider import divider_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic                   CLK,
  input logic                   RST,
  repeated_sub_divider_if.slave bus
);

  divider_state_t   state_r;
  divider_state_t   state_next_s;
  logic [WIDTH-1:0] divisor_r;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;
  logic             div_by_zero_r;
  logic             ge_s;
  logic             busy_s;
  logic             done_s;

  // Compare precedes subtract, so the subtraction can never underflow.
  assign ge_s = (remainder_r >= divisor_r);

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          // A zero divisor skips RUN entirely and reports in the next cycle.
          state_next_s = (bus.divisor == {WIDTH{1'b0}}) ? DONE : RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (ge_s) begin
          state_next_s = RUN;
        end else begin
          state_next_s = DONE;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // Operand latch and quotient/remainder datapath.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      divisor_r     <= {WIDTH{1'b0}};
      quotient_r    <= {WIDTH{1'b0}};
      remainder_r   <= {WIDTH{1'b0}};
      div_by_zero_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            if (bus.divisor == {WIDTH{1'b0}}) begin
              quotient_r    <= {WIDTH{1'b1}};
              remainder_r   <= bus.dividend;
              div_by_zero_r <= 1'b1;
            end else begin
              divisor_r     <= bus.divisor;
              quotient_r    <= {WIDTH{1'b0}};
              remainder_r   <= bus.dividend;
              div_by_zero_r <= 1'b0;
            end
          end
        end
        RUN: begin
          // Quotient cannot wrap: at most 2^WIDTH-1 subtractions of a divisor >= 1.
          if (ge_s) begin
            remainder_r <= remainder_r - divisor_r;
            quotient_r  <= quotient_r + {{(WIDTH-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          quotient_r  <= quotient_r;
          remainder_r <= remainder_r;
        end
      endcase
    end
  end

  // Status outputs decoded directly from the state register.
  always_comb begin
    busy_s = 1'b0;
    done_s = 1'b0;
    case (state_r)
      IDLE: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
      RUN: begin
        busy_s = 1'b1;
        done_s = 1'b0;
      end
      DONE: begin
        busy_s = 1'b1;
        done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
        done_s = 1'b0;
      end
    endcase
  end

  assign bus.busy        = busy_s;
  assign bus.done        = done_s;
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = div_by_zero_r;

endmodule

// File: tb/tb_repeated_sub_divider.sv
// Directed self-checking bench for repeated_sub_divider (WIDTH=8).
module tb_repeated_sub_divider;
  import divider_pkg::*;

  localparam int W = 8;

  logic CLK;
  logic RST;
  int   n_err;
  int   n_checks;

  repeated_sub_divider_if #(.WIDTH(W)) dif ();

  repeated_sub_divider #(.WIDTH(W)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (dif.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just past it.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Issue a one-cycle start pulse and wait for done; checks results and latency.
  task automatic run_div(input string tag, input int a, input int b,
                         input int exp_q, input int exp_r, input int exp_z,
                         input int exp_lat);
    int lat;
    dif.start    = 1'b1;
    dif.dividend = a[W-1:0];
    dif.divisor  = b[W-1:0];
    step();  // accepting edge
    dif.start = 1'b0;
    check({tag, "_busy_after_accept"}, 32'(dif.busy), 32'd1);
    lat = 0;
    while (dif.done !== 1'b1 && lat < 400) begin
      step();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "_quotient"}, 32'(dif.quotient), 32'(exp_q));
    check({tag, "_remainder"}, 32'(dif.remainder), 32'(exp_r));
    check({tag, "_dbz"}, 32'(dif.div_by_zero), 32'(exp_z));
    step();
    check({tag, "_done_one_cycle"}, 32'(dif.done), 32'd0);
    check({tag, "_idle_after"}, 32'(dif.busy), 32'd0);
  endtask

  initial begin
    int dones;
    int lat;
    int divs [6];
    n_err       = 0;
    n_checks    = 0;
    RST         = 1'b1;
    dif.start   = 1'b0;
    dif.dividend = 8'd0;
    dif.divisor  = 8'd0;
    divs = '{1, 2, 3, 17, 128, 255};

    step();
    step();
    check("rst_busy", 32'(dif.busy), 32'd0);
    check("rst_done", 32'(dif.done), 32'd0);
    check("rst_quotient", 32'(dif.quotient), 32'd0);
    check("rst_remainder", 32'(dif.remainder), 32'd0);
    check("rst_dbz", 32'(dif.div_by_zero), 32'd0);
    RST = 1'b0;
    step();

    // Nominal and boundary divisions.
    run_div("d200_7", 200, 7, 28, 4, 0, 29);
    run_div("d255_1", 255, 1, 255, 0, 0, 256);
    run_div("d5_9", 5, 9, 0, 5, 0, 1);
    run_div("d0_4", 0, 4, 0, 0, 0, 1);
    run_div("d13_13", 13, 13, 1, 0, 0, 2);
    run_div("d254_255", 254, 255, 0, 254, 0, 1);

    // Divide by zero, then a normal division clears the flag.
    run_div("d77_0", 77, 0, 255, 77, 1, 0);
    repeat (3) step();
    check("dbz_hold_flag", 32'(dif.div_by_zero), 32'd1);
    check("dbz_hold_q", 32'(dif.quotient), 32'd255);
    run_div("d10_2", 10, 2, 5, 0, 0, 6);

    // Start while busy is ignored.
    dif.start    = 1'b1;
    dif.dividend = 8'd100;
    dif.divisor  = 8'd10;
    step();
    dif.dividend = 8'd9;
    dif.divisor  = 8'd3;
    step();
    step();
    dif.start = 1'b0;
    lat = 0;
    while (dif.done !== 1'b1 && lat < 400) begin
      step();
      lat++;
    end
    check("busy_ignore_q", 32'(dif.quotient), 32'd10);
    check("busy_ignore_r", 32'(dif.remainder), 32'd0);
    step();

    // Start held high: one IDLE cycle between consecutive done pulses.
    dif.start    = 1'b1;
    dif.dividend = 8'd12;
    dif.divisor  = 8'd4;
    lat = 0;
    while (dif.done !== 1'b1 && lat < 400) begin
      step();
      lat++;
    end
    check("held_first_q", 32'(dif.quotient), 32'd3);
    step();
    check("held_idle_gap_busy", 32'(dif.busy), 32'd0);
    step();
    check("held_reaccept_busy", 32'(dif.busy), 32'd1);
    check("held_reaccept_done", 32'(dif.done), 32'd0);
    lat = 0;
    while (dif.done !== 1'b1 && lat < 400) begin
      step();
      lat++;
    end
    check("held_second_lat", 32'(lat), 32'd4);
    check("held_second_q", 32'(dif.quotient), 32'd3);
    dif.start = 1'b0;
    step();
    step();

    // Reset in the middle of 200/3 aborts immediately.
    dif.start    = 1'b1;
    dif.dividend = 8'd200;
    dif.divisor  = 8'd3;
    step();
    dif.start = 1'b0;
    repeat (10) step();
    check("pre_rst_busy", 32'(dif.busy), 32'd1);
    RST = 1'b1;
    #1;
    check("mid_rst_busy", 32'(dif.busy), 32'd0);
    check("mid_rst_quotient", 32'(dif.quotient), 32'd0);
    check("mid_rst_remainder", 32'(dif.remainder), 32'd0);
    check("mid_rst_state", 32'(dut.state_r), 32'(IDLE));
    step();
    RST = 1'b0;
    dones = 0;
    repeat (300) begin
      step();
      if (dif.done === 1'b1) dones++;
    end
    check("no_done_after_rst", 32'(dones), 32'd0);

    // Sampled sweep against the / and % operators.
    for (int a = 0; a < 256; a += 37) begin
      for (int k = 0; k < 6; k++) begin
        run_div("sweep", a, divs[k], a / divs[k], a % divs[k], 0, (a / divs[k]) + 1);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
